prog_frame_loader: RTL and testbench
====================================

# prog_frame_loader

Framed UART programming loader for the boot RAM's secondary port. It consumes the byte stream arriving from the UART clock-domain-crossing FIFO, one byte per `progValid` pulse with no backpressure. It parses a fixed-format frame into 32-bit word writes and arbitrates the memory port between the CPU-side bus and the loader. It sits between the CDC FIFO output and port B of the boot RAM.

## Interface
- `ADDR_WIDTH`, 12: word-address width of the target RAM.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_BITS`, 20: idle-byte timeout counter width; timeout is 2^TIMEOUT_BITS cycles.
- `clk`  in  1  memory-side clock; all logic on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `progEn`  in  1  programming mode; 0 means the bus passes through.
- `progData`  in  8  received byte.
- `progValid`  in  1  `progData` valid this cycle, at most one byte per cycle.
- `addrIn`  in  ADDR_WIDTH  CPU-side address.
- `dataIn`  in  32  CPU-side write data.
- `weIn`  in  4  CPU-side byte write enables.
- `enIn`  in  1  CPU-side enable.
- `addrOut`  out  ADDR_WIDTH  RAM address.
- `dataOut`  out  32  RAM write data.
- `weOut`  out  4  RAM byte write enables.
- `enOut`  out  1  RAM enable.
- `busy`  out  1  frame in progress (any state past SYNC).
- `done`  out  1  one-cycle pulse at frame end.
- `err`  out  1  sticky frame error.

## Operation
- Frame layout: SYNC, addrLo, addrHi, cntLo, cntHi, then cnt×4 data bytes (little-endian per word), then chk.
  - Start word address = {addrHi, addrLo}[ADDR_WIDTH-1:0]; upper bits are ignored.
  - cnt is a 16-bit word count; 0 is legal and means no data bytes.
  - chk is chosen so that the 8-bit sum of all bytes from addrLo through chk is 0.
- States:
  - IDLE: entered while `progEn`=0.
  - SYNC: waits for a SYNC byte. Other bytes are discarded silently.
  - HDR: collects 4 bytes; an internal index counts 0..3.
  - DATA: packs bytes into words. After each 4th byte it issues one write, then increments the address modulo 2^ADDR_WIDTH and decrements the remaining count. When the count reaches 0 it moves to CSUM. If cnt=0 the HDR state goes directly to CSUM.
  - CSUM: consumes chk, pulses `done`, sets `err` on mismatch, and returns to SYNC.
- Mux: while `progEn`=0, the outputs equal the corresponding inputs combinationally. While `progEn`=1, the loader drives the outputs from registers:
  - `enOut`=1 and `weOut`=4'hF only in the write cycle.
  - Otherwise `enOut`=0, `weOut`=0, and address/data hold their last values.
- `progEn` falling mid-frame aborts to IDLE immediately. Words already written stay written, `err` is unchanged, and there is no `done`.
- Timeout: in HDR, DATA or CSUM, if 2^TIMEOUT_BITS cycles pass with no `progValid`, the loader returns to SYNC, sets `err`, and does not pulse `done`. A byte arriving in the expiry cycle takes precedence and reloads the counter.
- `err` clears when the SYNC byte of the next frame is accepted.
- Writes are not rolled back on checksum failure; `err` is the only indication.

## Timing
- Reset values:
  - State = SYNC if `progEn`=1, else IDLE.
  - Registered `addrOut`=0, `dataOut`=0, `weOut`=0, `enOut`=0.
  - `busy`=0, `done`=0, `err`=0, checksum=0, timeout counter=0.
- Write latency: the write strobe is registered and asserted in the cycle after the 4th byte of a word is accepted.
- Back-to-back bytes every cycle are sustained with no byte lost.
- `done` asserts in the cycle after chk is accepted, coincident with the return to SYNC.
- `busy` rises in the cycle after SYNC is accepted and falls with `done`, on timeout, or on abort.
- `progEn` rising moves IDLE→SYNC on the next edge. Bytes in that same edge's cycle are ignored.

## Configuration
- `PROG_CHECKSUM_EN` defined: the running sum is maintained and a mismatch in CSUM sets `err`.
- `PROG_CHECKSUM_EN` undefined: the chk byte is still consumed, the adder is removed, and only a timeout can set `err`.

## Structure
- Package `prog_pkg` holds:
  - the state enumeration (IDLE, SYNC, HDR, DATA, CSUM);
  - the default SYNC_BYTE constant;
  - the header length constant (4) and the word byte count (4).
- Sub-module `prog_word_packer`: shifts 4 bytes into a 32-bit word, LSB first, and emits a one-cycle `wordValid`. It clears on frame start and on abort.

## Test plan
- SYNC A5; addr 10 00; cnt 02 00; data 11 22 33 44 55 66 77 88; correct chk → writes 0x44332211 at 0x010 and 0x88776655 at 0x011, each with `weOut`=F. `done` pulses once; `err`=0.
- Same frame with chk+1 → both writes still occur, and `err`=1 after `done` (only when `PROG_CHECKSUM_EN` is defined).
- addr FF 0F, cnt 2 → writes at 0xFFF then 0x000 (wrap-around).
- Stall for 2^TIMEOUT_BITS cycles (TIMEOUT_BITS=4 in the bench) after 2 data bytes → return to SYNC with `err`=1 and no `done`. The next valid frame clears `err`.
- Drop `progEn` in the middle of DATA → `enOut` follows `enIn` in the same cycle, and a subsequent frame with `progEn`=1 parses correctly from SYNC.
- Garbage bytes 00 FF before SYNC, plus the cnt=0 frame A5 00 00 00 00 00 → no writes, `done` pulses, `err`=0.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared definitions for the framed UART programming loader: loader states,
// default frame marker and the fixed frame field sizes.
package prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_HDR  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } prog_state_e;

    localparam logic [7:0] PROG_SYNC_BYTE  = 8'hA5;
    localparam int         PROG_HDR_LEN    = 4;
    localparam int         PROG_WORD_BYTES = 4;

    // A frame is "in progress" once the marker has been taken.
    function automatic logic state_is_busy(input prog_state_e s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/prog_word_packer.sv
// Assembles four received bytes into one little-endian 32-bit word. The first
// byte of a word lands in bits [7:0]. word_valid_o is high for the single
// cycle in which the fourth byte is presented, with word_o already complete.
module prog_word_packer
    import prog_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LAST_IDX = 2'(PROG_WORD_BYTES - 1);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;

    // Shift bytes in from the top so the earliest byte ends up lowest.
    always_comb begin
        idx_d        = idx_q;
        shift_d      = shift_q;
        word_valid_o = 1'b0;
        word_o       = {byte_i, shift_q};
        if (clear_i) begin
            idx_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid_i) begin
            shift_d = {byte_i, shift_q[23:8]};
            if (idx_q == LAST_IDX) begin
                word_valid_o = 1'b1;
                idx_d        = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    // Byte index and partial-word storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/prog_frame_loader.sv
// Framed UART programming loader in front of boot RAM port B.
// Frame: SYNC, addrLo, addrHi, cntLo, cntHi, cnt*4 data bytes, chk.
// When progEn is low the CPU-side bus passes straight through to the RAM.
// Optional feature macro: PROG_CHECKSUM_EN (enables the running-sum check).
module prog_frame_loader
    import prog_pkg::*;
#(
    parameter int         ADDR_WIDTH   = 12,
    parameter logic [7:0] SYNC_BYTE    = PROG_SYNC_BYTE,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  progEn,
    input  logic [7:0]            progData,
    input  logic                  progValid,
    input  logic [ADDR_WIDTH-1:0] addrIn,
    input  logic [31:0]           dataIn,
    input  logic [3:0]            weIn,
    input  logic                  enIn,
    output logic [ADDR_WIDTH-1:0] addrOut,
    output logic [31:0]           dataOut,
    output logic [3:0]            weOut,
    output logic                  enOut,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] HDR_LAST = 2'(PROG_HDR_LEN - 1);

    prog_state_e             state_q, state_d, state_cur;
    logic                    post_rst_q;
    logic [1:0]              hdr_idx_q, hdr_idx_d;
    logic [23:0]             hdr_q, hdr_d;
    logic [ADDR_WIDTH-1:0]   addr_ptr_q, addr_ptr_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic [31:0]             out_data_q, out_data_d;
    logic                    out_en_q, out_en_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
`ifdef PROG_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    logic                    pk_clear;
    logic                    pk_valid;
    logic                    pk_word_valid;
    logic [31:0]             pk_word;

    prog_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rstn),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_i       (progData),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    // Coming out of reset with progEn already high behaves as if SYNC was the
    // reset state; otherwise IDLE must first see progEn to reach SYNC.
    assign state_cur = (state_q == ST_IDLE && post_rst_q && progEn) ? ST_SYNC : state_q;

    // Frame parser: next state, header/word capture, timeout and status flags.
    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        hdr_d      = hdr_q;
        addr_ptr_d = addr_ptr_q;
        cnt_d      = cnt_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_en_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        tmo_d      = tmo_q;
`ifdef PROG_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        pk_clear   = 1'b0;
        pk_valid   = 1'b0;

        if (!progEn) begin
            // Abort: drop the frame, keep err and anything already written.
            state_d   = ST_IDLE;
            hdr_idx_d = 2'd0;
            tmo_d     = '0;
            pk_clear  = 1'b1;
        end else begin
            case (state_cur)
                ST_IDLE: begin
                    // Byte arriving alongside the progEn rise is ignored.
                    state_d = ST_SYNC;
                    tmo_d   = '0;
                end
                ST_SYNC: begin
                    tmo_d = '0;
                    if (progValid && progData == SYNC_BYTE) begin
                        state_d   = ST_HDR;
                        hdr_idx_d = 2'd0;
                        err_d     = 1'b0;
                        pk_clear  = 1'b1;
`ifdef PROG_CHECKSUM_EN
                        csum_d    = 8'd0;
`endif
                    end
                end
                ST_HDR, ST_DATA, ST_CSUM: begin
                    if (progValid) begin
                        tmo_d = '0;
`ifdef PROG_CHECKSUM_EN
                        csum_d = csum_q + progData;
`endif
                        if (state_cur == ST_HDR) begin
                            hdr_d = {progData, hdr_q[23:8]};
                            if (hdr_idx_q == HDR_LAST) begin
                                hdr_idx_d  = 2'd0;
                                addr_ptr_d = ADDR_WIDTH'(hdr_q[15:0]);
                                cnt_d      = {progData, hdr_q[23:16]};
                                state_d    = ({progData, hdr_q[23:16]} == 16'd0) ? ST_CSUM : ST_DATA;
                            end else begin
                                hdr_idx_d = hdr_idx_q + 2'd1;
                            end
                        end else if (state_cur == ST_DATA) begin
                            pk_valid = 1'b1;
                            if (pk_word_valid) begin
                                out_en_d   = 1'b1;
                                out_addr_d = addr_ptr_q;
                                out_data_d = pk_word;
                                addr_ptr_d = addr_ptr_q + 1'b1;
                                cnt_d      = cnt_q - 16'd1;
                                if (cnt_q == 16'd1) begin
                                    state_d = ST_CSUM;
                                end
                            end
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_SYNC;
`ifdef PROG_CHECKSUM_EN
                            if ((csum_q + progData) != 8'd0) begin
                                err_d = 1'b1;
                            end
`endif
                        end
                    end else if (tmo_q == '1) begin
                        // Link went quiet mid-frame: give up and flag it.
                        state_d = ST_SYNC;
                        err_d   = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            post_rst_q <= 1'b1;
            hdr_idx_q  <= 2'd0;
            hdr_q      <= 24'd0;
            addr_ptr_q <= '0;
            cnt_q      <= 16'd0;
            out_addr_q <= '0;
            out_data_q <= 32'd0;
            out_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            post_rst_q <= 1'b0;
            hdr_idx_q  <= hdr_idx_d;
            hdr_q      <= hdr_d;
            addr_ptr_q <= addr_ptr_d;
            cnt_q      <= cnt_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

`ifdef PROG_CHECKSUM_EN
    // Running 8-bit sum of every byte after the marker.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Port B mux: CPU bus passes through combinationally unless programming.
    assign addrOut = progEn ? out_addr_q     : addrIn;
    assign dataOut = progEn ? out_data_q     : dataIn;
    assign weOut   = progEn ? {4{out_en_q}}  : weIn;
    assign enOut   = progEn ? out_en_q       : enIn;

    assign busy = progEn && state_is_busy(state_q);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_prog_frame_loader.sv
// Self-checking bench for prog_frame_loader (TIMEOUT_BITS=4).
module tb_prog_frame_loader;

    localparam int AW = 12;
    localparam int TB = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          progEn = 1'b1;
    logic [7:0]    progData = 8'd0;
    logic          progValid = 1'b0;
    logic [AW-1:0] addrIn = '0;
    logic [31:0]   dataIn = 32'd0;
    logic [3:0]    weIn = 4'd0;
    logic          enIn = 1'b0;
    logic [AW-1:0] addrOut;
    logic [31:0]   dataOut;
    logic [3:0]    weOut;
    logic          enOut;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    prog_frame_loader #(
        .ADDR_WIDTH   (AW),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_BITS (TB)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .progEn    (progEn),
        .progData  (progData),
        .progValid (progValid),
        .addrIn    (addrIn),
        .dataIn    (dataIn),
        .weIn      (weIn),
        .enIn      (enIn),
        .addrOut   (addrOut),
        .dataOut   (dataOut),
        .weOut     (weOut),
        .enOut     (enOut),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int errors = 0;
    int checks = 0;

    // Observed RAM writes and done pulses while the loader owns the port.
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [3:0]    wr_we_q[$];
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (rstn && progEn) begin
            if (enOut) begin
                wr_addr_q.push_back(addrOut);
                wr_data_q.push_back(dataOut);
                wr_we_q.push_back(weOut);
            end
            if (done) done_cnt++;
        end
    end

    // Words the reference model expects for the frame being sent.
    logic [31:0] exp_words[$];

    // Reference address of the i-th word of a frame starting at a.
    function automatic logic [AW-1:0] model_addr(input logic [15:0] a, input int i);
        int v;
        v = (int'(a) + i) % (1 << AW);
        return v[AW-1:0];
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        progData  = b;
        progValid = 1'b1;
        @(posedge clk);
        #1;
        progValid = 1'b0;
        progData  = 8'($urandom);
        tick(gap);
    endtask

    // Build a frame from the address, exp_words and a checksum offset.
    task automatic send_frame(input logic [15:0] a, input logic [7:0] chk_delta, input int gap_max);
        logic [7:0]  fb[$];
        logic [7:0]  sum;
        logic [15:0] n;
        logic [31:0] w;
        n = 16'(exp_words.size());
        fb.push_back(a[7:0]);
        fb.push_back(a[15:8]);
        fb.push_back(n[7:0]);
        fb.push_back(n[15:8]);
        for (int i = 0; i < exp_words.size(); i++) begin
            w = exp_words[i];
            for (int k = 0; k < 4; k++) fb.push_back(w[8*k +: 8]);
        end
        sum = 8'd0;
        foreach (fb[i]) sum = sum + fb[i];
        fb.push_back(8'(8'd0 - sum + chk_delta));
        send_byte(8'hA5, $urandom_range(0, gap_max));
        foreach (fb[i]) send_byte(fb[i], $urandom_range(0, gap_max));
        tick(3);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        progEn = 1'b1;
        tick(2);
        checks++; if (addrOut !== 12'h000) begin errors++; $display("FAIL reset_addr got=%h exp=000", addrOut); end
        checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", dataOut); end
        checks++; if (weOut !== 4'h0) begin errors++; $display("FAIL reset_we got=%h exp=0", weOut); end
        checks++; if (enOut !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", enOut); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rstn = 1'b1;
        tick(2);
        $display("reset: released with progEn=1");
    endtask

    task automatic run_and_check(input string name, input logic [15:0] a, input logic [7:0] delta,
                                 input int gap_max, input logic exp_err);
        int wb, db, nw;
        wb = wr_addr_q.size();
        db = done_cnt;
        send_frame(a, delta, gap_max);
        nw = wr_addr_q.size() - wb;
        checks++; if (nw !== exp_words.size()) begin errors++; $display("FAIL %s_wcount got=%0d exp=%0d", name, nw, exp_words.size()); end
        for (int i = 0; i < exp_words.size() && i < nw; i++) begin
            checks++; if (wr_addr_q[wb+i] !== model_addr(a, i)) begin errors++; $display("FAIL %s_addr[%0d] got=%h exp=%h", name, i, wr_addr_q[wb+i], model_addr(a, i)); end
            checks++; if (wr_data_q[wb+i] !== exp_words[i]) begin errors++; $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, wr_data_q[wb+i], exp_words[i]); end
            checks++; if (wr_we_q[wb+i] !== 4'hF) begin errors++; $display("FAIL %s_we[%0d] got=%h exp=F", name, i, wr_we_q[wb+i]); end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL %s_done got=%0d exp=1", name, done_cnt - db); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL %s_err got=%b exp=%b", name, err, exp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got=%b exp=0", name, busy); end
        $display("%s: addr=%h words=%0d writes=%0d err=%b", name, a, exp_words.size(), nw, err);
    endtask

    task automatic test_basic();
        exp_words.delete();
        exp_words.push_back(32'h44332211);
        exp_words.push_back(32'h88776655);
        run_and_check("basic", 16'h0010, 8'd0, 1, 1'b0);
    endtask

    task automatic test_bad_chk();
        logic exp_e;
`ifdef PROG_CHECKSUM_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        exp_words.delete();
        exp_words.push_back(32'h44332211);
        exp_words.push_back(32'h88776655);
        run_and_check("bad_chk", 16'h0010, 8'd1, 1, exp_e);
    endtask

    task automatic test_garbage_cnt0();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        exp_words.delete();
        run_and_check("cnt0", 16'h0000, 8'd0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        exp_words.delete();
        exp_words.push_back($urandom);
        exp_words.push_back($urandom);
        run_and_check("wrap", 16'h0FFF, 8'd0, 2, 1'b0);
    endtask

    task automatic test_timeout();
        int wb, db;
        logic [15:0] a;
        a = 16'($urandom);
        wb = wr_addr_q.size();
        db = done_cnt;
        send_byte(8'hA5, 0);
        send_byte(a[7:0], 0);
        send_byte(a[15:8], 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'($urandom), 1);
        send_byte(8'($urandom), 0);
        tick((1 << TB) - 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy_before got=%b exp=1", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_before got=%b exp=0", err); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy_after got=%b exp=0", busy); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_after got=%b exp=1", err); end
        tick(3);
        checks++; if (done_cnt - db !== 0) begin errors++; $display("FAIL tmo_done got=%0d exp=0", done_cnt - db); end
        checks++; if (wr_addr_q.size() - wb !== 0) begin errors++; $display("FAIL tmo_writes got=%0d exp=0", wr_addr_q.size() - wb); end
        $display("timeout: stalled after 2 data bytes, err=%b busy=%b", err, busy);
        exp_words.delete();
        exp_words.push_back($urandom);
        run_and_check("after_tmo", 16'($urandom), 8'd0, 2, 1'b0);
    endtask

    task automatic test_abort();
        int wb, db;
        logic [15:0] a;
        a = 16'($urandom);
        exp_words.delete();
        for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
        wb = wr_addr_q.size();
        db = done_cnt;
        send_byte(8'hA5, 0);
        send_byte(a[7:0], 0);
        send_byte(a[15:8], 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] w;
            w = exp_words[i / 4];
            send_byte(w[8*(i%4) +: 8], 0);
        end
        progEn = 1'b0;
        addrIn = AW'($urandom);
        dataIn = $urandom;
        weIn   = 4'($urandom);
        enIn   = 1'b1;
        #1;
        checks++; if (enOut !== 1'b1) begin errors++; $display("FAIL abort_en1 got=%b exp=1", enOut); end
        checks++; if (addrOut !== addrIn) begin errors++; $display("FAIL abort_addr got=%h exp=%h", addrOut, addrIn); end
        checks++; if (dataOut !== dataIn) begin errors++; $display("FAIL abort_data got=%h exp=%h", dataOut, dataIn); end
        checks++; if (weOut !== weIn) begin errors++; $display("FAIL abort_we got=%h exp=%h", weOut, weIn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        enIn = 1'b0;
        #1;
        checks++; if (enOut !== 1'b0) begin errors++; $display("FAIL abort_en0 got=%b exp=0", enOut); end
        tick(2);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err got=%b exp=0", err); end
        checks++; if (done_cnt - db !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", done_cnt - db); end
        checks++; if (wr_addr_q.size() - wb !== 1) begin errors++; $display("FAIL abort_writes got=%0d exp=1", wr_addr_q.size() - wb); end
        else begin
            checks++; if (wr_data_q[wb] !== exp_words[0]) begin errors++; $display("FAIL abort_word0 got=%h exp=%h", wr_data_q[wb], exp_words[0]); end
        end
        $display("abort: progEn dropped mid-DATA, writes=%0d", wr_addr_q.size() - wb);
        // Marker offered together with progEn rising must be ignored.
        progEn    = 1'b1;
        progData  = 8'hA5;
        progValid = 1'b1;
        tick(1);
        progValid = 1'b0;
        exp_words.delete();
        exp_words.push_back($urandom);
        exp_words.push_back($urandom);
        run_and_check("after_abort", 16'($urandom), 8'd0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            exp_words.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) exp_words.push_back($urandom);
            run_and_check("b2b", 16'($urandom), 8'd0, 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_chk();
        test_garbage_cnt0();
        test_wrap();
        test_timeout();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
